// File: rtl/seq_mlp_if.sv
// ---------------------------------------------------------------------------
// seq_mlp_if
// Handshake bundle between the feature-vector source, the sequential MLP
// engine and the classifier post-processing.
//
// Signals:
//   in_valid          source -> engine : Input_Layer_Data is valid
//   in_ready          engine -> source : engine can take a vector
//   Input_Layer_Data  source -> engine : packed input vector, element i at [i*DW +: DW]
//   out_valid         engine -> sink   : Output_Data is valid
//   out_ready         sink   -> engine : sink takes the result
//   Output_Data       engine -> sink   : packed result vector
//
// Modports:
//   master : the side that supplies vectors and consumes results
//   slave  : the engine itself
// ---------------------------------------------------------------------------
interface seq_mlp_if #(
   parameter int DataWidth       = 8,
   parameter int N_InputNeurons  = 192,
   parameter int N_OutputNeurons = 4
);
   logic                                   in_valid;
   logic                                   in_ready;
   logic [DataWidth*N_InputNeurons-1:0]    Input_Layer_Data;
   logic                                   out_valid;
   logic                                   out_ready;
   logic [DataWidth*N_OutputNeurons-1:0]   Output_Data;

   modport master (
      output in_valid,
      output Input_Layer_Data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  Output_Data
   );

   modport slave (
      input  in_valid,
      input  Input_Layer_Data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output Output_Data
   );
endinterface

// File: rtl/seq_mlp_engine.sv
// ---------------------------------------------------------------------------
// seq_mlp_engine
// Time-multiplexed fully-connected inference engine. A single signed
// multiply-accumulate unit walks every neuron of N_HiddenLayer ReLU hidden
// layers followed by one linear output layer. Activations ping-pong between
// two buffers; the input vector lands in buffer A.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   bus (slave)           in_valid/in_ready/Input_Layer_Data and
//                         out_valid/out_ready/Output_Data handshakes
//   Weights_Layer_1       input-to-hidden-1 weights, (j*N_In+i)*DW packing
//   Bias_Layer_1          hidden-1 biases
//   Weights_Hidden        hidden layers 2..N, layer k in slice k-2
//   Bias_Hidden           biases for hidden layers 2..N
//   Weights_Output_Layer  hidden-to-output weights
//   Bias_Output_Layer     output biases
//   busy                  high whenever the FSM is not idle
//
// Configuration macro:
//   SEQ_MLP_SAT_EN  defined   : neuron results saturate to the DW range
//                   undefined : neuron results wrap to the low DW bits
//
// Weight and bias buses must be stable from acceptance until out_valid.
// ---------------------------------------------------------------------------
module seq_mlp_engine #(
   parameter int DataWidth       = 8,
   parameter int FracBits        = 4,
   parameter int N_HiddenLayer   = 2,
   parameter int N_InputNeurons  = 192,
   parameter int N_HiddenNeurons = 16,
   parameter int N_OutputNeurons = 4
) (
   input  logic clk,
   input  logic rst,
   seq_mlp_if.slave bus,
   input  logic [DataWidth*N_HiddenNeurons*N_InputNeurons-1:0] Weights_Layer_1,
   input  logic [DataWidth*N_HiddenNeurons-1:0] Bias_Layer_1,
   input  logic [((N_HiddenLayer > 1) ? DataWidth*N_HiddenNeurons*N_HiddenNeurons*(N_HiddenLayer-1) : 1)-1:0] Weights_Hidden,
   input  logic [((N_HiddenLayer > 1) ? DataWidth*N_HiddenNeurons*(N_HiddenLayer-1) : 1)-1:0] Bias_Hidden,
   input  logic [DataWidth*N_OutputNeurons*N_HiddenNeurons-1:0] Weights_Output_Layer,
   input  logic [DataWidth*N_OutputNeurons-1:0] Bias_Output_Layer,
   output logic busy
);

   localparam int DW     = DataWidth;
   localparam int NIn    = N_InputNeurons;
   localparam int NH     = N_HiddenNeurons;
   localparam int NO     = N_OutputNeurons;
   localparam int NHL    = N_HiddenLayer;
   localparam int MaxN   = (NIn > NH) ? NIn : NH;
   localparam int MaxCnt = (MaxN > NO) ? MaxN : NO;
   localparam int CntW   = $clog2(MaxCnt + 1);
   localparam int LayW   = $clog2(NHL + 1);
   localparam int ProdW  = 2 * DW;
   localparam int AccW   = 2 * DW + $clog2(MaxN) + 1;

   localparam logic [CntW-1:0] LastInC  = CntW'(NIn - 1);
   localparam logic [CntW-1:0] LastHidC = CntW'(NH - 1);
   localparam logic [CntW-1:0] LastOutC = CntW'(NO - 1);
   localparam logic [LayW-1:0] OutLayC  = LayW'(NHL);

`ifdef SEQ_MLP_SAT_EN
   localparam logic signed [AccW-1:0] SatMax = AccW'((1 << (DW - 1)) - 1);
   localparam logic signed [AccW-1:0] SatMin = ~SatMax;
`endif

   typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

   state_t                  state_q, state_d;
   logic [LayW-1:0]         layer_q, layer_d;
   logic [CntW-1:0]         neuron_q, neuron_d;
   logic [CntW-1:0]         inIdx_q, inIdx_d;
   logic                    sel_q, sel_d;
   logic signed [AccW-1:0]  acc_q, acc_d;

   logic signed [DW-1:0]    bufA_q [MaxN];
   logic signed [DW-1:0]    bufB_q [MaxN];
   logic signed [DW-1:0]    outArr_q [NO];

   logic                    capture;
   logic                    writeEn;
   logic                    lastIn;
   logic                    lastNeuron;
   logic                    isOutLayer;

   logic signed [DW-1:0]    xSel;
   logic signed [DW-1:0]    wL1, wHid, wOut, wSel;
   logic signed [DW-1:0]    bL1, bHid, bOut, bSel;
   logic signed [ProdW-1:0] prod;
   logic signed [AccW-1:0]  prodExt;
   logic signed [AccW-1:0]  biasExt;
   logic signed [DW-1:0]    narrow;
   logic signed [DW-1:0]    actOut;
   logic [DW*NO-1:0]        outFlat;
`ifdef SEQ_MLP_SAT_EN
   logic signed [AccW-1:0]  rShift;
`endif

   // Pick the activation feeding the multiplier: the buffer that holds the
   // previous layer, indexed by the current fan-in position.
   always_comb begin
      xSel = '0;
      for (int k = 0; k < MaxN; k++) begin
         if (inIdx_q == CntW'(k)) begin
            xSel = sel_q ? bufB_q[k] : bufA_q[k];
         end
      end
   end

   // Weight and bias lookup for the current (layer, neuron, input). Each flat
   // bus is shifted down to the addressed word and truncated to one word, then
   // the layer index chooses between first hidden, later hidden and output.
   always_comb begin
      wL1  = DW'(Weights_Layer_1 >> ((int'(neuron_q) * NIn + int'(inIdx_q)) * DW));
      bL1  = DW'(Bias_Layer_1 >> (int'(neuron_q) * DW));
      wHid = DW'(Weights_Hidden >> (((int'(layer_q) - 1) * NH * NH + int'(neuron_q) * NH + int'(inIdx_q)) * DW));
      bHid = DW'(Bias_Hidden >> (((int'(layer_q) - 1) * NH + int'(neuron_q)) * DW));
      wOut = DW'(Weights_Output_Layer >> ((int'(neuron_q) * NH + int'(inIdx_q)) * DW));
      bOut = DW'(Bias_Output_Layer >> (int'(neuron_q) * DW));
      isOutLayer = (layer_q == OutLayC);
      if (layer_q == '0) begin
         wSel = wL1;
         bSel = bL1;
      end else if (isOutLayer) begin
         wSel = wOut;
         bSel = bOut;
      end else begin
         wSel = wHid;
         bSel = bHid;
      end
      prod    = ProdW'(wSel) * ProdW'(xSel);
      prodExt = AccW'(prod);
      biasExt = AccW'(bSel) <<< FracBits;
   end

   // Turn the finished accumulator into a stored word: drop the fractional
   // product bits with a flooring shift, narrow to one word, and apply ReLU
   // on every layer except the output layer.
   always_comb begin
`ifdef SEQ_MLP_SAT_EN
      rShift = acc_q >>> FracBits;
      if (rShift > SatMax) begin
         narrow = DW'(SatMax);
      end else if (rShift < SatMin) begin
         narrow = DW'(SatMin);
      end else begin
         narrow = DW'(rShift);
      end
`else
      narrow = DW'(acc_q >>> FracBits);
`endif
      if (!isOutLayer && narrow[DW-1]) begin
         actOut = '0;
      end else begin
         actOut = narrow;
      end
   end

   // Next-state logic. A neuron is PreN MAC cycles (bias folded into the
   // first) followed by one WRITE cycle; WRITE also advances neuron/layer and
   // swaps the ping-pong buffers at a layer boundary.
   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      neuron_d = neuron_q;
      inIdx_d  = inIdx_q;
      sel_d    = sel_q;
      acc_d    = acc_q;
      capture  = 1'b0;
      writeEn  = 1'b0;

      lastIn     = (layer_q == '0) ? (inIdx_q == LastInC) : (inIdx_q == LastHidC);
      lastNeuron = isOutLayer ? (neuron_q == LastOutC) : (neuron_q == LastHidC);

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               capture  = 1'b1;
               layer_d  = '0;
               neuron_d = '0;
               inIdx_d  = '0;
               sel_d    = 1'b0;
               state_d  = MAC;
            end
         end
         MAC: begin
            if (inIdx_q == '0) begin
               acc_d = biasExt + prodExt;
            end else begin
               acc_d = acc_q + prodExt;
            end
            if (lastIn) begin
               inIdx_d = '0;
               state_d = WRITE;
            end else begin
               inIdx_d = inIdx_q + 1'b1;
            end
         end
         WRITE: begin
            writeEn = 1'b1;
            if (lastNeuron) begin
               if (isOutLayer) begin
                  state_d = DONE;
               end else begin
                  layer_d  = layer_q + 1'b1;
                  neuron_d = '0;
                  sel_d    = ~sel_q;
                  state_d  = MAC;
               end
            end else begin
               neuron_d = neuron_q + 1'b1;
               state_d  = MAC;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and accumulator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         layer_q  <= '0;
         neuron_q <= '0;
         inIdx_q  <= '0;
         sel_q    <= 1'b0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         neuron_q <= neuron_d;
         inIdx_q  <= inIdx_d;
         sel_q    <= sel_d;
         acc_q    <= acc_d;
      end
   end

   // Activation buffers and the result register. The input vector always
   // lands in buffer A; a hidden neuron is written into whichever buffer is
   // not currently being read, and output neurons go to the result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < MaxN; k++) begin
            bufA_q[k] <= '0;
            bufB_q[k] <= '0;
         end
         for (int k = 0; k < NO; k++) begin
            outArr_q[k] <= '0;
         end
      end else begin
         if (capture) begin
            for (int k = 0; k < NIn; k++) begin
               bufA_q[k] <= bus.Input_Layer_Data[k*DW +: DW];
            end
         end
         if (writeEn) begin
            if (isOutLayer) begin
               for (int k = 0; k < NO; k++) begin
                  if (neuron_q == CntW'(k)) begin
                     outArr_q[k] <= actOut;
                  end
               end
            end else begin
               for (int k = 0; k < NH; k++) begin
                  if (neuron_q == CntW'(k)) begin
                     if (sel_q) begin
                        bufA_q[k] <= actOut;
                     end else begin
                        bufB_q[k] <= actOut;
                     end
                  end
               end
            end
         end
      end
   end

   // Pack the result words onto the flat output bus.
   always_comb begin
      outFlat = '0;
      for (int k = 0; k < NO; k++) begin
         outFlat[k*DW +: DW] = outArr_q[k];
      end
   end

   assign bus.Output_Data = outFlat;
   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_seq_mlp_engine.sv
// ---------------------------------------------------------------------------
// tb_seq_mlp_engine
// Directed bench for seq_mlp_engine. Two instances: dutA is the small
// integer network (2 in, 1 hidden layer of 2, 1 out, FracBits=0) and dutB is
// the Q4.4 depth network (1 in, 2 hidden layers of 1, 1 out).
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_seq_mlp_engine;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   // A 10-unit clock period; outputs are sampled 1 unit after the rising edge.
   always #5 clk = ~clk;

   seq_mlp_if #(.DataWidth(8), .N_InputNeurons(2), .N_OutputNeurons(1)) busA ();
   seq_mlp_if #(.DataWidth(8), .N_InputNeurons(1), .N_OutputNeurons(1)) busB ();

   logic [31:0] w1A;
   logic [15:0] b1A;
   logic [0:0]  whA;
   logic [0:0]  bhA;
   logic [15:0] woA;
   logic [7:0]  boA;
   logic        busyA;

   logic [7:0]  w1B;
   logic [7:0]  b1B;
   logic [7:0]  whB;
   logic [7:0]  bhB;
   logic [7:0]  woB;
   logic [7:0]  boB;
   logic        busyB;

`ifdef SEQ_MLP_SAT_EN
   localparam logic [7:0] ExpSat = 8'd127;
`else
   localparam logic [7:0] ExpSat = 8'd0;
`endif

   seq_mlp_engine #(
      .DataWidth(8), .FracBits(0), .N_HiddenLayer(1),
      .N_InputNeurons(2), .N_HiddenNeurons(2), .N_OutputNeurons(1)
   ) dutA (
      .clk(clk), .rst(rst), .bus(busA),
      .Weights_Layer_1(w1A), .Bias_Layer_1(b1A),
      .Weights_Hidden(whA), .Bias_Hidden(bhA),
      .Weights_Output_Layer(woA), .Bias_Output_Layer(boA),
      .busy(busyA)
   );

   seq_mlp_engine #(
      .DataWidth(8), .FracBits(4), .N_HiddenLayer(2),
      .N_InputNeurons(1), .N_HiddenNeurons(1), .N_OutputNeurons(1)
   ) dutB (
      .clk(clk), .rst(rst), .bus(busB),
      .Weights_Layer_1(w1B), .Bias_Layer_1(b1B),
      .Weights_Hidden(whB), .Bias_Hidden(bhB),
      .Weights_Output_Layer(woB), .Bias_Output_Layer(boB),
      .busy(busyB)
   );

   // Offer one vector to dutA once it is ready; ok reports acceptance.
   task automatic applyStimulusA(input logic [15:0] d, output logic ok);
      int n;
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      while (!busA.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busA.in_ready) begin
         busA.Input_Layer_Data = d;
         busA.in_valid = 1'b1;
         @(posedge clk);
         #1;
         busA.in_valid = 1'b0;
         ok = 1'b1;
      end
   endtask

   task automatic applyStimulusB(input logic [7:0] d, output logic ok);
      int n;
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      while (!busB.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busB.in_ready) begin
         busB.Input_Layer_Data = d;
         busB.in_valid = 1'b1;
         @(posedge clk);
         #1;
         busB.in_valid = 1'b0;
         ok = 1'b1;
      end
   endtask

   // Count edges after acceptance until out_valid, bounded.
   task automatic waitOutA(output int e);
      e = 0;
      while (busA.out_valid !== 1'b1 && e < 200) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   task automatic waitOutB(output int e);
      e = 0;
      while (busB.out_valid !== 1'b1 && e < 200) begin
         @(posedge clk);
         #1;
         e++;
      end
   endtask

   task automatic setBasicWeights();
      w1A = 32'h00FF_0101;
      b1A = 16'h0000;
      woA = 16'h0502;
      boA = 8'h01;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total += 8;
      if (busA.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_A got=%b want=1", busA.in_ready); end
      if (busA.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid_A got=%b want=0", busA.out_valid); end
      if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_A got=%b want=0", busyA); end
      if (busA.Output_Data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data_A got=%h want=00", busA.Output_Data); end
      if (busB.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready_B got=%b want=1", busB.in_ready); end
      if (busB.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid_B got=%b want=0", busB.out_valid); end
      if (busyB !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_B got=%b want=0", busyB); end
      if (busB.Output_Data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data_B got=%h want=00", busB.Output_Data); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Three vectors through the 2-2-1 integer network, latency 9 each.
   task automatic test_basic();
      logic [15:0] vin [3];
      logic [7:0]  vexp [3];
      logic        ok;
      int          e;
      vin[0] = 16'hFE03; vexp[0] = 8'd3;
      vin[1] = 16'h02FC; vexp[1] = 8'd21;
      vin[2] = 16'h0105; vexp[2] = 8'd13;
      setBasicWeights();
      busA.out_ready = 1'b1;
      for (int v = 0; v < 3; v++) begin
         applyStimulusA(vin[v], ok);
         waitOutA(e);
         total += 3;
         if (ok !== 1'b1) begin bad++; $display("[TB] FAIL basic_accept[%0d] got=%b want=1", v, ok); end
         if (e != 9) begin bad++; $display("[TB] FAIL basic_latency[%0d] got=%0d want=9", v, e); end
         if (busA.Output_Data !== vexp[v]) begin bad++; $display("[TB] FAIL basic_out[%0d] got=%h want=%h", v, busA.Output_Data, vexp[v]); end
      end
   endtask

   // 100+100 overflows the word: wraps to -56 (ReLU 0) or saturates to 127.
   task automatic test_saturation();
      logic ok;
      int   e;
      w1A = 32'h0000_0101;
      b1A = 16'h0000;
      woA = 16'h0001;
      boA = 8'h00;
      busA.out_ready = 1'b1;
      applyStimulusA(16'h6464, ok);
      waitOutA(e);
      total += 2;
      if (e != 9) begin bad++; $display("[TB] FAIL sat_latency got=%0d want=9", e); end
      if (busA.Output_Data !== ExpSat) begin bad++; $display("[TB] FAIL sat_out got=%h want=%h", busA.Output_Data, ExpSat); end
   endtask

   // Q4.4 through two hidden layers: identity, flooring/negative bias, ReLU.
   task automatic test_fixed_point();
      logic ok;
      int   e;
      w1B = 8'h10; b1B = 8'h00; whB = 8'h10; bhB = 8'h00; woB = 8'h10; boB = 8'h00;
      busB.out_ready = 1'b1;
      applyStimulusB(8'h18, ok);
      waitOutB(e);
      total += 2;
      if (e != 6) begin bad++; $display("[TB] FAIL fp_latency got=%0d want=6", e); end
      if (busB.Output_Data !== 8'h18) begin bad++; $display("[TB] FAIL fp_identity got=%h want=18", busB.Output_Data); end

      w1B = 8'h18; boB = 8'hF0;
      applyStimulusB(8'h03, ok);
      waitOutB(e);
      total += 2;
      if (e != 6) begin bad++; $display("[TB] FAIL fp_latency2 got=%0d want=6", e); end
      if (busB.Output_Data !== 8'hF4) begin bad++; $display("[TB] FAIL fp_floor_neg got=%h want=f4", busB.Output_Data); end

      w1B = 8'h10; boB = 8'h00;
      applyStimulusB(8'hE8, ok);
      waitOutB(e);
      total += 1;
      if (busB.Output_Data !== 8'h00) begin bad++; $display("[TB] FAIL fp_relu got=%h want=00", busB.Output_Data); end
   endtask

   // Hold the result under out_ready=0 while in_valid pulses; release it.
   task automatic test_backpressure();
      logic ok;
      int   e;
      setBasicWeights();
      busA.out_ready = 1'b0;
      applyStimulusA(16'hFE03, ok);
      waitOutA(e);
      total += 2;
      if (e != 9) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=9", e); end
      if (busA.Output_Data !== 8'd3) begin bad++; $display("[TB] FAIL bp_out got=%h want=03", busA.Output_Data); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         busA.Input_Layer_Data = 16'h0105;
         busA.in_valid = (c == 1) || (c == 2);
         @(posedge clk);
         #1;
         total += 3;
         if (busA.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid[%0d] got=%b want=1", c, busA.out_valid); end
         if (busA.Output_Data !== 8'd3) begin bad++; $display("[TB] FAIL bp_hold_data[%0d] got=%h want=03", c, busA.Output_Data); end
         if (busA.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready[%0d] got=%b want=0", c, busA.in_ready); end
      end
      @(negedge clk);
      busA.in_valid = 1'b0;
      busA.out_ready = 1'b1;
      @(posedge clk);
      #1;
      total += 2;
      if (busA.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%b want=1", busA.in_ready); end
      if (busA.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid got=%b want=0", busA.out_valid); end
      repeat (3) @(posedge clk);
      #1;
      total += 2;
      if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_second_accept got=%b want=0", busyA); end
      if (busA.Output_Data !== 8'd3) begin bad++; $display("[TB] FAIL bp_data_after got=%h want=03", busA.Output_Data); end
   endtask

   // Reset sampled at edge 4 of a run aborts it; a fresh run then completes.
   task automatic test_reset_mid_mac();
      logic ok;
      int   e;
      setBasicWeights();
      busA.out_ready = 1'b1;
      applyStimulusA(16'h0105, ok);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total += 4;
      if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy got=%b want=0", busyA); end
      if (busA.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmid_out_valid got=%b want=0", busA.out_valid); end
      if (busA.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmid_in_ready got=%b want=1", busA.in_ready); end
      if (busA.Output_Data !== 8'h00) begin bad++; $display("[TB] FAIL rmid_data got=%h want=00", busA.Output_Data); end
      @(negedge clk);
      rst = 1'b0;
      applyStimulusA(16'hFE03, ok);
      waitOutA(e);
      total += 2;
      if (e != 9) begin bad++; $display("[TB] FAIL rmid_latency got=%0d want=9", e); end
      if (busA.Output_Data !== 8'd3) begin bad++; $display("[TB] FAIL rmid_out got=%h want=03", busA.Output_Data); end
   endtask

   // in_valid and out_ready held high: acceptances are L+2 = 11 edges apart.
   task automatic test_back_to_back();
      logic rdy;
      int   cnt;
      int   first;
      int   second;
      int   e;
      setBasicWeights();
      busA.out_ready = 1'b1;
      cnt = 0;
      first = -1;
      second = -1;
      @(negedge clk);
      busA.Input_Layer_Data = 16'h02FC;
      busA.in_valid = 1'b1;
      while (second < 0 && cnt < 100) begin
         rdy = busA.in_ready;
         @(posedge clk);
         cnt++;
         if (rdy) begin
            if (first < 0) first = cnt;
            else second = cnt;
         end
         @(negedge clk);
      end
      busA.in_valid = 1'b0;
      total += 1;
      if (second - first != 11) begin bad++; $display("[TB] FAIL b2b_period got=%0d want=11", second - first); end
      waitOutA(e);
      total += 2;
      if (e != 9) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=9", e); end
      if (busA.Output_Data !== 8'd21) begin bad++; $display("[TB] FAIL b2b_out got=%h want=15", busA.Output_Data); end
   endtask

   initial begin
      rst = 1'b1;
      busA.in_valid = 1'b0;
      busA.out_ready = 1'b1;
      busA.Input_Layer_Data = '0;
      busB.in_valid = 1'b0;
      busB.out_ready = 1'b1;
      busB.Input_Layer_Data = '0;
      w1A = '0; b1A = '0; whA = '0; bhA = '0; woA = '0; boA = '0;
      w1B = '0; b1B = '0; whB = '0; bhB = '0; woB = '0; boB = '0;
      test_reset();
      test_basic();
      test_saturation();
      test_fixed_point();
      test_backpressure();
      test_reset_mid_mac();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
